// File: rtl/alu_pkg.sv
// Shared encodings for the sequential ALU: ALUOp classes, opcodes, 4-bit ALU control codes
// and the execute FSM state encoding.
package alu_pkg;

    localparam int unsigned ALUOP_W = 2;
    localparam int unsigned OPC_W   = 4;
    localparam int unsigned FUNCT_W = 2;
    localparam int unsigned CTRL_W  = 4;

    localparam logic [ALUOP_W-1:0] ALUOP_LDST  = 2'b00;
    localparam logic [ALUOP_W-1:0] ALUOP_BEQ   = 2'b01;
    localparam logic [ALUOP_W-1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [ALUOP_W-1:0] ALUOP_ITYPE = 2'b11;

    localparam logic [OPC_W-1:0] OPC_LOGIC = 4'b0000;
    localparam logic [OPC_W-1:0] OPC_ARITH = 4'b0001;
    localparam logic [OPC_W-1:0] OPC_SHIFT = 4'b0010;
    localparam logic [OPC_W-1:0] OPC_ADDI  = 4'b1001;
    localparam logic [OPC_W-1:0] OPC_SUBI  = 4'b1010;
    localparam logic [OPC_W-1:0] OPC_SLTI  = 4'b1011;

    typedef enum logic [CTRL_W-1:0] {
        CTRL_AND = 4'b0000,
        CTRL_SLT = 4'b0001,
        CTRL_OR  = 4'b0010,
        CTRL_XOR = 4'b0011,
        CTRL_ADD = 4'b0100,
        CTRL_SLL = 4'b0110,
        CTRL_SRA = 4'b0111,
        CTRL_MUL = 4'b1000,
        CTRL_SUB = 4'b1100
    } alu_ctrl_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_MUL  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational ALU-control decoder: ALUOp/OPCODE/Funct to 4-bit control code plus illegal flag.
module alu_ctrl_decode
    import alu_pkg::*;
#(
    parameter int unsigned MUL_EN = 1
) (
    input  logic [ALUOP_W-1:0] alu_op_i,
    input  logic [OPC_W-1:0]   opcode_i,
    input  logic [FUNCT_W-1:0] funct_i,
    output alu_ctrl_e          ctrl_o,
    output logic               illegal_o
);

    always_comb begin
        ctrl_o    = CTRL_ADD;
        illegal_o = 1'b0;
        case (alu_op_i)
            ALUOP_LDST: ctrl_o = CTRL_ADD;
            ALUOP_BEQ:  ctrl_o = CTRL_SUB;
            ALUOP_RTYPE: begin
                case (opcode_i)
                    OPC_LOGIC: begin
                        case (funct_i)
                            2'b00:   ctrl_o = CTRL_AND;
                            2'b01:   ctrl_o = CTRL_OR;
                            2'b10:   ctrl_o = CTRL_XOR;
                            default: illegal_o = 1'b1;
                        endcase
                    end
                    OPC_ARITH: begin
                        case (funct_i)
                            2'b00:   ctrl_o = CTRL_ADD;
                            2'b01:   ctrl_o = CTRL_SUB;
                            2'b10: begin
                                // Builds without the multiplier reject MUL as an undefined op
                                if (MUL_EN != 0) ctrl_o = CTRL_MUL;
                                else             illegal_o = 1'b1;
                            end
                            default: illegal_o = 1'b1;
                        endcase
                    end
                    OPC_SHIFT: begin
                        case (funct_i)
                            2'b00:   ctrl_o = CTRL_SLL;
                            2'b01:   ctrl_o = CTRL_SRA;
                            default: illegal_o = 1'b1;
                        endcase
                    end
                    default: illegal_o = 1'b1;
                endcase
            end
            ALUOP_ITYPE: begin
                case (opcode_i)
                    OPC_ADDI: ctrl_o = CTRL_ADD;
                    OPC_SUBI: ctrl_o = CTRL_SUB;
                    OPC_SLTI: ctrl_o = CTRL_SLT;
                    default:  illegal_o = 1'b1;
                endcase
            end
            default: illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_exec_seq.sv
// Sequential ALU execute stage: decodes the op, runs single-cycle ops or an iterative
// shift-add multiply, and presents Result/flags behind valid/ready handshakes.
module alu_exec_seq
    import alu_pkg::*;
#(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned MUL_EN  = 1,
    parameter int unsigned SHAMT_W = $clog2(DATA_W)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic [ALUOP_W-1:0] alu_op_i,
    input  logic [OPC_W-1:0]   opcode_i,
    input  logic [FUNCT_W-1:0] funct_i,
    input  logic [DATA_W-1:0]  a_i,
    input  logic [DATA_W-1:0]  b_i,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [DATA_W-1:0]  result_o,
    output logic               zero_o,
    output logic               overflow_o,
    output logic               illegal_op_o
);

    localparam int unsigned CNT_W  = $clog2(DATA_W);
    localparam int unsigned PROD_W = 2 * DATA_W;
    localparam int unsigned MSB    = DATA_W - 1;

    state_e              state_q, state_d;
    alu_ctrl_e           ctrl_c;
    logic                illegal_c, is_mul_c, accept_c, mul_last_c;
    logic [DATA_W-1:0]   sum_c, diff_c, exe_res_c;
    logic                exe_ovf_c;
    logic [SHAMT_W-1:0]  shamt_c;
    logic [PROD_W-1:0]   acc_step_c;

    logic [DATA_W-1:0]   result_q, result_d;
    logic                zero_q, zero_d, ovf_q, ovf_d, ill_q, ill_d;
    logic [PROD_W-1:0]   acc_q, acc_d, mcand_q, mcand_d;
    logic [DATA_W-1:0]   mplr_q, mplr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    alu_ctrl_decode #(.MUL_EN(MUL_EN)) u_dec (
        .alu_op_i  (alu_op_i),
        .opcode_i  (opcode_i),
        .funct_i   (funct_i),
        .ctrl_o    (ctrl_c),
        .illegal_o (illegal_c)
    );

    assign is_mul_c   = !illegal_c && (ctrl_c == CTRL_MUL);
    assign accept_c   = in_valid_i && in_ready_o;
    assign mul_last_c = (state_q == ST_MUL) && (cnt_q == CNT_W'(DATA_W - 1));
    assign shamt_c    = b_i[SHAMT_W-1:0];
    assign sum_c      = a_i + b_i;
    assign diff_c     = a_i - b_i;
    assign acc_step_c = acc_q + (mplr_q[0] ? mcand_q : '0);

    // Single-cycle execute
    always_comb begin
        exe_res_c = '0;
        exe_ovf_c = 1'b0;
        case (ctrl_c)
            CTRL_AND: exe_res_c = a_i & b_i;
            CTRL_OR:  exe_res_c = a_i | b_i;
            CTRL_XOR: exe_res_c = a_i ^ b_i;
            CTRL_ADD: begin
                exe_res_c = sum_c;
                exe_ovf_c = (a_i[MSB] == b_i[MSB]) && (sum_c[MSB] != a_i[MSB]);
            end
            CTRL_SUB: begin
                exe_res_c = diff_c;
                exe_ovf_c = (a_i[MSB] != b_i[MSB]) && (diff_c[MSB] != a_i[MSB]);
            end
            CTRL_SLT: exe_res_c = DATA_W'($signed(a_i) < $signed(b_i));
            CTRL_SLL: exe_res_c = a_i << shamt_c;
            CTRL_SRA: exe_res_c = $signed(a_i) >>> shamt_c;
            default:  exe_res_c = '0;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept_c) state_d = is_mul_c ? ST_MUL : ST_DONE;
            ST_MUL:  if (mul_last_c) state_d = ST_DONE;
            ST_DONE: begin
                if (out_ready_i) begin
                    if (accept_c) state_d = is_mul_c ? ST_MUL : ST_DONE;
                    else          state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs; a pending result may be handed off on the same edge a new op is taken
    always_comb begin
        in_ready_o  = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready_i);
        out_valid_o = (state_q == ST_DONE);
    end

    // Result capture and one-bit-per-cycle shift-add multiply
    always_comb begin
        result_d = result_q;
        zero_d   = zero_q;
        ovf_d    = ovf_q;
        ill_d    = ill_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplr_d   = mplr_q;
        cnt_d    = cnt_q;
        if (accept_c) begin
            if (illegal_c) begin
                result_d = '0;
                zero_d   = 1'b1;
                ovf_d    = 1'b0;
                ill_d    = 1'b1;
            end else if (is_mul_c) begin
                acc_d   = '0;
                mcand_d = PROD_W'(a_i);
                mplr_d  = b_i;
                cnt_d   = '0;
                ill_d   = 1'b0;
            end else begin
                result_d = exe_res_c;
                zero_d   = (exe_res_c == '0);
                ovf_d    = exe_ovf_c;
                ill_d    = 1'b0;
            end
        end else if (state_q == ST_MUL) begin
            acc_d   = acc_step_c;
            mcand_d = mcand_q << 1;
            mplr_d  = mplr_q >> 1;
            cnt_d   = cnt_q + CNT_W'(1);
            if (mul_last_c) begin
                result_d = acc_step_c[DATA_W-1:0];
                zero_d   = (acc_step_c[DATA_W-1:0] == '0);
                ovf_d    = |acc_step_c[PROD_W-1:DATA_W];
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            result_q <= '0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
            ill_q    <= 1'b0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplr_q   <= '0;
            cnt_q    <= '0;
        end else begin
            result_q <= result_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
            ill_q    <= ill_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplr_q   <= mplr_d;
            cnt_q    <= cnt_d;
        end
    end

    assign result_o     = result_q;
    assign zero_o       = zero_q;
    assign overflow_o   = ovf_q;
    assign illegal_op_o = ill_q;

endmodule
